// File: rtl/addsub_cnt_mod.sv
// addsub_cnt_mod: parametrised up/down counter with programmable modulus and step.
// It can wrap or saturate at its bounds, and is used as a timebase or address generator.
//
// Ports:
//   CLK      rising-edge clock
//   RST      synchronous reset, active-high (DOUT, COUT and ERR cleared)
//   EN       count enable
//   LOAD     synchronous load of DATA; acts regardless of EN
//   UP       1 = count up, 0 = count down
//   MODE     0 = wrap modulo MAXV+1, 1 = saturate at 0 / MAXV
//   STEP     increment/decrement amount
//   MAXV     inclusive upper bound of the count range
//   DATA     load value
//   CLR_ERR  clears the sticky error flag
//   DOUT     registered count
//   COUT     registered one-cycle pulse: bound crossed or clamped on the previous edge
//   TC       combinational terminal count: at MAXV counting up, or at 0 counting down
//   ERR      sticky error: illegal load, step larger than MAXV, or count above MAXV
module addsub_cnt_mod #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STEP_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              LOAD,
  input  logic              UP,
  input  logic              MODE,
  input  logic [STEP_W-1:0] STEP,
  input  logic [WIDTH-1:0]  MAXV,
  input  logic [WIDTH-1:0]  DATA,
  input  logic              CLR_ERR,
  output logic [WIDTH-1:0]  DOUT,
  output logic              COUT,
  output logic              TC,
  output logic              ERR
);

  // One extra bit so that MAXV+1 is representable when MAXV is all ones.
  logic [WIDTH:0]   d_ext;
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   m1_ext;
  logic [WIDTH:0]   s_ext;
  logic [WIDTH:0]   sum_ext;

  logic [WIDTH-1:0] nxt_dout;
  logic             nxt_cout;
  logic             err_set;

  assign d_ext   = {1'b0, DOUT};
  assign m_ext   = {1'b0, MAXV};
  assign m1_ext  = m_ext + {{WIDTH{1'b0}}, 1'b1};
  assign s_ext   = (WIDTH+1)'(STEP);
  assign sum_ext = d_ext + s_ext;

  always_comb begin
    nxt_dout = DOUT;
    nxt_cout = 1'b0;
    err_set  = 1'b0;
    if (LOAD) begin
      if (DATA > MAXV) begin
        nxt_dout = MAXV;
        err_set  = 1'b1;
      end else begin
        nxt_dout = DATA;
      end
    end else if (EN) begin
      if (s_ext == '0) begin
        nxt_dout = DOUT;
      end else if (s_ext > m_ext) begin
        err_set = 1'b1;
      end else if (d_ext > m_ext) begin
        // MAXV was lowered below the current count: pull back into range.
        nxt_dout = MAXV;
        err_set  = 1'b1;
      end else if (UP) begin
        if (sum_ext > m_ext) begin
          nxt_dout = MODE ? MAXV : WIDTH'(sum_ext - m1_ext);
          nxt_cout = 1'b1;
        end else begin
          nxt_dout = WIDTH'(sum_ext);
        end
      end else begin
        if (d_ext >= s_ext) begin
          nxt_dout = WIDTH'(d_ext - s_ext);
        end else begin
          nxt_dout = MODE ? '0 : WIDTH'(d_ext + m1_ext - s_ext);
          nxt_cout = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      DOUT <= '0;
      COUT <= 1'b0;
      ERR  <= 1'b0;
    end else begin
      DOUT <= nxt_dout;
      COUT <= nxt_cout;
      // A new error on the same edge as CLR_ERR keeps the flag set.
      ERR  <= err_set | (ERR & ~CLR_ERR);
    end
  end

  assign TC = UP ? (DOUT == MAXV) : (DOUT == '0);

endmodule

// File: tb/tb_addsub_cnt_mod.sv
// tb_addsub_cnt_mod: directed self-checking bench for addsub_cnt_mod (WIDTH=16, STEP_W=4).
module tb_addsub_cnt_mod;

  logic        CLK = 1'b0;
  logic        RST, EN, LOAD, UP, MODE, CLR_ERR;
  logic [3:0]  STEP;
  logic [15:0] MAXV, DATA;
  logic [15:0] DOUT;
  logic        COUT, TC, ERR;

  int n_checks = 0;
  int n_fail   = 0;

  addsub_cnt_mod #(.WIDTH(16), .STEP_W(4)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .LOAD(LOAD), .UP(UP), .MODE(MODE),
    .STEP(STEP), .MAXV(MAXV), .DATA(DATA), .CLR_ERR(CLR_ERR),
    .DOUT(DOUT), .COUT(COUT), .TC(TC), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // Advance one rising edge and settle; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      RST     = 1'b1;
      EN      = 1'($urandom);
      LOAD    = 1'($urandom);
      UP      = 1'($urandom);
      MODE    = 1'($urandom);
      CLR_ERR = 1'($urandom);
      STEP    = 4'($urandom);
      DATA    = 16'($urandom);
      MAXV    = 16'($urandom_range(1, 65535));
      tick();
      n_checks++;
      if (DOUT !== 16'd0 || COUT !== 1'b0 || ERR !== 1'b0) begin
        n_fail++;
        $display("FAIL reset[%0d]: DOUT=%0d COUT=%b ERR=%b, required 0/0/0", i, DOUT, COUT, ERR);
      end
      n_checks++;
      if (TC !== !UP) begin
        n_fail++;
        $display("FAIL reset_tc[%0d]: TC=%b, required %b (UP=%b)", i, TC, !UP, UP);
      end
    end
  endtask

  task automatic test_wrap_up();
    logic [15:0] exp_d [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    RST = 1'b0; LOAD = 1'b0; CLR_ERR = 1'b0;
    MAXV = 16'd9; STEP = 4'd1; UP = 1'b1; MODE = 1'b0; EN = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_checks++;
      if (DOUT !== exp_d[i] || COUT !== (i == 9) || TC !== (exp_d[i] == 16'd9)) begin
        n_fail++;
        $display("FAIL wrap_up[%0d]: DOUT=%0d COUT=%b TC=%b, required %0d/%b/%b",
                 i, DOUT, COUT, TC, exp_d[i], (i == 9), (exp_d[i] == 16'd9));
      end
    end
  endtask

  task automatic test_wrap_down();
    logic [15:0] exp_d [4] = '{8, 4, 0, 6};
    logic        exp_c [4] = '{1, 0, 0, 1};
    EN = 1'b0; LOAD = 1'b1; DATA = 16'd2; MAXV = 16'd9; STEP = 4'd4; UP = 1'b0; MODE = 1'b0;
    tick();
    n_checks++;
    if (DOUT !== 16'd2 || COUT !== 1'b0) begin
      n_fail++;
      $display("FAIL load2: DOUT=%0d COUT=%b, required 2/0", DOUT, COUT);
    end
    LOAD = 1'b0; EN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (DOUT !== exp_d[i] || COUT !== exp_c[i] || TC !== (exp_d[i] == 16'd0)) begin
        n_fail++;
        $display("FAIL wrap_down[%0d]: DOUT=%0d COUT=%b TC=%b, required %0d/%b/%b",
                 i, DOUT, COUT, TC, exp_d[i], exp_c[i], (exp_d[i] == 16'd0));
      end
    end
    // Hold with EN=0: count frozen, COUT drops.
    EN = 1'b0;
    tick();
    n_checks++;
    if (DOUT !== 16'd6 || COUT !== 1'b0) begin
      n_fail++;
      $display("FAIL hold: DOUT=%0d COUT=%b, required 6/0", DOUT, COUT);
    end
  endtask

  task automatic test_saturate();
    EN = 1'b0; LOAD = 1'b1; DATA = 16'd7; MAXV = 16'd9; STEP = 4'd4; UP = 1'b1; MODE = 1'b1;
    tick();
    LOAD = 1'b0; EN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (DOUT !== 16'd9 || COUT !== 1'b1 || TC !== 1'b1) begin
        n_fail++;
        $display("FAIL sat_up[%0d]: DOUT=%0d COUT=%b TC=%b, required 9/1/1", i, DOUT, COUT, TC);
      end
    end
    // Down from 1 with step 4 clamps at 0 and keeps pulsing.
    EN = 1'b0; LOAD = 1'b1; DATA = 16'd1; UP = 1'b0;
    tick();
    LOAD = 1'b0; EN = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (DOUT !== 16'd0 || COUT !== 1'b1 || TC !== 1'b1) begin
        n_fail++;
        $display("FAIL sat_dn[%0d]: DOUT=%0d COUT=%b TC=%b, required 0/1/1", i, DOUT, COUT, TC);
      end
    end
  endtask

  task automatic test_full_width();
    EN = 1'b0; LOAD = 1'b1; DATA = 16'hFFFF; MAXV = 16'hFFFF; STEP = 4'd1; UP = 1'b1; MODE = 1'b0;
    tick();
    n_checks++;
    if (DOUT !== 16'hFFFF || TC !== 1'b1) begin
      n_fail++;
      $display("FAIL full_load: DOUT=%h TC=%b, required ffff/1", DOUT, TC);
    end
    LOAD = 1'b0; EN = 1'b1;
    tick();
    n_checks++;
    if (DOUT !== 16'h0000 || COUT !== 1'b1 || ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL full_wrap: DOUT=%h COUT=%b ERR=%b, required 0000/1/0", DOUT, COUT, ERR);
    end
    tick();
    n_checks++;
    if (DOUT !== 16'h0001 || COUT !== 1'b0) begin
      n_fail++;
      $display("FAIL full_next: DOUT=%h COUT=%b, required 0001/0", DOUT, COUT);
    end
  endtask

  task automatic test_errors();
    EN = 1'b0; LOAD = 1'b1; DATA = 16'd20; MAXV = 16'd9; STEP = 4'd1; UP = 1'b1; MODE = 1'b0;
    tick();
    n_checks++;
    if (DOUT !== 16'd9 || ERR !== 1'b1 || COUT !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_load: DOUT=%0d ERR=%b COUT=%b, required 9/1/0", DOUT, ERR, COUT);
    end
    LOAD = 1'b0; EN = 1'b1; STEP = 4'd12;
    tick();
    n_checks++;
    if (DOUT !== 16'd9 || ERR !== 1'b1 || COUT !== 1'b0) begin
      n_fail++;
      $display("FAIL big_step: DOUT=%0d ERR=%b COUT=%b, required 9/1/0", DOUT, ERR, COUT);
    end
    // Set on the same edge as clear: flag stays set.
    CLR_ERR = 1'b1;
    tick();
    n_checks++;
    if (ERR !== 1'b1) begin
      n_fail++;
      $display("FAIL set_wins: ERR=%b, required 1", ERR);
    end
    EN = 1'b0;
    tick();
    n_checks++;
    if (ERR !== 1'b0 || DOUT !== 16'd9) begin
      n_fail++;
      $display("FAIL clr_err: ERR=%b DOUT=%0d, required 0/9", ERR, DOUT);
    end
    CLR_ERR = 1'b0;
    // Lower MAXV under the count: clamp and flag.
    LOAD = 1'b1; DATA = 16'd8;
    tick();
    LOAD = 1'b0; MAXV = 16'd5; STEP = 4'd1; EN = 1'b1;
    tick();
    n_checks++;
    if (DOUT !== 16'd5 || ERR !== 1'b1 || COUT !== 1'b0) begin
      n_fail++;
      $display("FAIL range: DOUT=%0d ERR=%b COUT=%b, required 5/1/0", DOUT, ERR, COUT);
    end
  endtask

  task automatic test_reset_mid();
    MAXV = 16'd9; STEP = 4'd1; UP = 1'b1; MODE = 1'b0; EN = 1'b1; LOAD = 1'b0;
    tick();
    RST = 1'b1;
    tick();
    n_checks++;
    if (DOUT !== 16'd0 || ERR !== 1'b0 || COUT !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst: DOUT=%0d ERR=%b COUT=%b, required 0/0/0", DOUT, ERR, COUT);
    end
    RST = 1'b0;
    tick();
    n_checks++;
    if (DOUT !== 16'd1) begin
      n_fail++;
      $display("FAIL post_rst: DOUT=%0d, required 1", DOUT);
    end
  endtask

  initial begin
    RST = 1'b1; EN = 1'b0; LOAD = 1'b0; UP = 1'b1; MODE = 1'b0; CLR_ERR = 1'b0;
    STEP = '0; MAXV = '0; DATA = '0;
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_full_width();
    test_errors();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
